pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Generates the select/enable lines consumed by the ALU-forwarding, ID-stall, PC and IF/ID datapath muxes
//  of the 5-stage MIPS pipeline. Covers forwarding, load-use and branch-in-ID stalls, redirect flush and data-memory wait freeze.
//  Sits beside the hazard/forwarding logic and drives Ctrl_FwdA/B, Ctrl_Mux_Select_Stall, PCWrite, IFID_Write/Flush.
//  Keeps saturating stall/flush performance counters.
// PARAMETERS
//  REG_ADDR_W   5    register-address width
//  CNT_W        32   width of performance counters
//  MEM_TIMEOUT  255  wait cycles in MEM_WAIT before Mem_Timeout_Err sets
// PORTS
//  clk                      in   1      rising-edge clock
//  reset                    in   1      asynchronous, active-high
//  IFID_Rs, IFID_Rt         in   5      source regs of instruction in ID
//  ID_UsesRt                in   1      ID instruction reads rt (R-type, beq/bne, sw)
//  ID_Branch, ID_JR         in   1      beq/bne / jr in ID (operands compared/used in ID)
//  ID_Redirect              in   1      ID resolves taken branch, j, jal or jr this cycle
//  IDEX_Rs, IDEX_Rt         in   5      EX-stage source regs
//  IDEX_WriteReg            in   5      EX-stage destination (post RegDst)
//  IDEX_RegWrite, IDEX_MemRead in 1     EX-stage controls
//  EXMEM_WriteReg           in   5      MEM-stage destination
//  EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemWrite in 1  MEM-stage controls
//  MEMWB_WriteReg           in   5      WB-stage destination
//  MEMWB_RegWrite           in   1      WB-stage write enable
//  Mem_Ready                in   1      data memory completes access this cycle
//  Ctrl_FwdA, Ctrl_FwdB     out  2      0 = register file, 1 = EX/MEM fwd, 2 = MEM/WB fwd
//  Ctrl_Mux_Select_Stall    out  1      1 = pass control unit, 0 = bubble
//  PCWrite, IFID_Write      out  1      PC / IF-ID load enables
//  IFID_Flush               out  1      clear IF/ID at next edge
//  Pipe_Freeze              out  1      hold ID/EX, EX/MEM, MEM/WB
//  Mem_Timeout_Err          out  1      sticky timeout flag
//  Stall_Count, Flush_Count out  CNT_W  saturating event counters
// BEHAVIOUR
//  Reset (async): state RUN, counters 0, Mem_Timeout_Err 0, wait counter 0. Outputs after reset with idle inputs:
//   FwdA/B 0, Select_Stall 1, PCWrite 1, IFID_Write 1, IFID_Flush 0, Pipe_Freeze 0.
//  Forwarding (comb, 0-cycle): FwdA = 1 if EXMEM_RegWrite & EXMEM_WriteReg!=0 & ==IDEX_Rs; else 2 if MEMWB match; else 0.
//   EX/MEM wins over MEM/WB. Same for FwdB with IDEX_Rt. Register 0 never forwarded. FwdA/B never 3.
//  Hazard (comb):
//   load_use = IDEX_MemRead & IDEX_WriteReg!=0 & (==IFID_Rs | (ID_UsesRt & ==IFID_Rt)).
//   br_haz = (ID_Branch|ID_JR) & [(IDEX_RegWrite & IDEX_WriteReg!=0 & matches used ID src) |
//            (EXMEM_MemRead & EXMEM_WriteReg!=0 & matches)]; jr uses Rs only.
//   stall = load_use | br_haz.
//  mem_busy = (EXMEM_MemRead|EXMEM_MemWrite) & !Mem_Ready.
//  FSM: RUN, MEM_WAIT.
//   RUN -> MEM_WAIT when mem_busy.
//   MEM_WAIT -> RUN when Mem_Ready.
//   Wait counter counts MEM_WAIT cycles. At MEM_TIMEOUT, Mem_Timeout_Err sets (sticky until reset); FSM keeps waiting.
//  Output priority (same cycle):
//   1. mem_busy: Pipe_Freeze=1, PCWrite=0, IFID_Write=0, IFID_Flush=0, Select_Stall=1 (hold, no bubble).
//   2. stall: PCWrite=0, IFID_Write=0, Select_Stall=0, IFID_Flush=0. ID_Redirect is ignored until the stall clears.
//   3. ID_Redirect: IFID_Flush=1, PCWrite=1.
//   4. else: pass-through.
//  Counters: Stall_Count +1 per cycle of case 2; Flush_Count +1 per cycle of case 3; frozen cycles do not count.
//   Both saturate at all-ones.
//  Load -> dependent beq produces 2 stall cycles: ID/EX load, then EX/MEM load.
//  A freeze arriving mid-stall holds the stall; the stall resumes after Mem_Ready.
//  Reset mid-MEM_WAIT: RUN immediately, flags cleared.
// STRUCTURE
//  Shared package hazard_pkg: FWD_REG=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2; state enum {RUN, MEM_WAIT}.
//  Sub-module sat_counter (CNT_W, en) instanced twice for Stall/Flush counters.
//  Forwarding, hazard and FSM logic stay in this module.
// TESTING
//  1. EXMEM_RegWrite=1 with dest 8, MEMWB_RegWrite=1 with dest 8, IDEX_Rs=8 -> FwdA=1. Dest 0 -> FwdA=0.
//  2. lw $9 in EX, ID add uses $9 -> 1 cycle: Select_Stall=0, PCWrite=0; next cycle pass-through; Stall_Count=1.
//  3. lw $9 then beq $9 in ID -> 2 stall cycles; Stall_Count=2, then ID_Redirect=1 -> IFID_Flush=1, Flush_Count=1.
//  4. sw in MEM, Mem_Ready low 3 cycles -> Pipe_Freeze high exactly 3 cycles; counters unchanged.
//  5. Mem_Ready held low MEM_TIMEOUT cycles -> Mem_Timeout_Err=1. Assert reset mid-wait -> error 0, state RUN.
//  6. Force Stall_Count to all-ones, then one more stall -> value unchanged.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the hazard/forwarding controller.
package hazard_pkg;
    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {RUN, MEM_WAIT} state_e;
endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (en && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Forwarding selects, stall/flush/freeze enables and perf counters for the
// 5-stage pipeline.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Branch,
    input  logic                  ID_JR,
    input  logic                  ID_Redirect,
    input  logic [REG_ADDR_W-1:0] IDEX_Rs,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt,
    input  logic [REG_ADDR_W-1:0] IDEX_WriteReg,
    input  logic                  IDEX_RegWrite,
    input  logic                  IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0] EXMEM_WriteReg,
    input  logic                  EXMEM_RegWrite,
    input  logic                  EXMEM_MemRead,
    input  logic                  EXMEM_MemWrite,
    input  logic [REG_ADDR_W-1:0] MEMWB_WriteReg,
    input  logic                  MEMWB_RegWrite,
    input  logic                  Mem_Ready,
    output logic [1:0]            Ctrl_FwdA,
    output logic [1:0]            Ctrl_FwdB,
    output logic                  Ctrl_Mux_Select_Stall,
    output logic                  PCWrite,
    output logic                  IFID_Write,
    output logic                  IFID_Flush,
    output logic                  Pipe_Freeze,
    output logic                  Mem_Timeout_Err,
    output logic [CNT_W-1:0]      Stall_Count,
    output logic [CNT_W-1:0]      Flush_Count
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    // $0 is hardwired, so a write to it never creates a dependency.
    function automatic logic hit(input logic we,
                                 input logic [REG_ADDR_W-1:0] dst,
                                 input logic [REG_ADDR_W-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

    logic load_use, br_haz, stall, mem_busy;
    logic stall_en, flush_en;
    state_e state;
    logic [WAIT_W-1:0] wait_cnt, wait_inc;

    always_comb begin
        Ctrl_FwdA = FWD_REG;
        if (hit(EXMEM_RegWrite, EXMEM_WriteReg, IDEX_Rs))      Ctrl_FwdA = FWD_EXMEM;
        else if (hit(MEMWB_RegWrite, MEMWB_WriteReg, IDEX_Rs)) Ctrl_FwdA = FWD_MEMWB;
        Ctrl_FwdB = FWD_REG;
        if (hit(EXMEM_RegWrite, EXMEM_WriteReg, IDEX_Rt))      Ctrl_FwdB = FWD_EXMEM;
        else if (hit(MEMWB_RegWrite, MEMWB_WriteReg, IDEX_Rt)) Ctrl_FwdB = FWD_MEMWB;
    end

    // Branches compare in ID, so they wait on any EX producer and on a load in MEM; jr reads rs only.
    assign load_use = hit(IDEX_MemRead, IDEX_WriteReg, IFID_Rs) ||
                      (ID_UsesRt && hit(IDEX_MemRead, IDEX_WriteReg, IFID_Rt));
    assign br_haz   = (ID_Branch || ID_JR) &&
                      (hit(IDEX_RegWrite, IDEX_WriteReg, IFID_Rs) ||
                       hit(EXMEM_MemRead, EXMEM_WriteReg, IFID_Rs) ||
                       (ID_Branch && (hit(IDEX_RegWrite, IDEX_WriteReg, IFID_Rt) ||
                                      hit(EXMEM_MemRead, EXMEM_WriteReg, IFID_Rt))));
    assign stall    = load_use || br_haz;
    assign mem_busy = (EXMEM_MemRead || EXMEM_MemWrite) && !Mem_Ready;

    always_comb begin
        Pipe_Freeze           = 1'b0;
        PCWrite               = 1'b1;
        IFID_Write            = 1'b1;
        IFID_Flush            = 1'b0;
        Ctrl_Mux_Select_Stall = 1'b1;
        if (mem_busy) begin
            Pipe_Freeze = 1'b1;
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
        end else if (stall) begin
            PCWrite               = 1'b0;
            IFID_Write            = 1'b0;
            Ctrl_Mux_Select_Stall = 1'b0;
        end else if (ID_Redirect) begin
            IFID_Flush = 1'b1;
        end
    end

    assign stall_en = !mem_busy && stall;
    assign flush_en = !mem_busy && !stall && ID_Redirect;
    assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= '0;
            Mem_Timeout_Err <= 1'b0;
        end else begin
            case (state)
                RUN: if (mem_busy) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= wait_inc;
                    if (wait_inc >= WAIT_MAX) Mem_Timeout_Err <= 1'b1;
                end
                MEM_WAIT: if (Mem_Ready) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_inc;
                    if (wait_inc >= WAIT_MAX) Mem_Timeout_Err <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .en(stall_en), .count(Stall_Count));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .en(flush_en), .count(Flush_Count));
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;
    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 16;

    logic clk = 1'b0, reset = 1'b1;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rs, IDEX_Rt, IDEX_WriteReg, EXMEM_WriteReg, MEMWB_WriteReg;
    logic ID_UsesRt, ID_Branch, ID_JR, ID_Redirect, IDEX_RegWrite, IDEX_MemRead;
    logic EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemWrite, MEMWB_RegWrite, Mem_Ready;
    logic [1:0] Ctrl_FwdA, Ctrl_FwdB;
    logic Ctrl_Mux_Select_Stall, PCWrite, IFID_Write, IFID_Flush, Pipe_Freeze, Mem_Timeout_Err;
    logic [CNT_W-1:0] Stall_Count, Flush_Count;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_ADDR_W(5), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_JR(ID_JR), .ID_Redirect(ID_Redirect),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_WriteReg(IDEX_WriteReg),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .EXMEM_WriteReg(EXMEM_WriteReg), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
        .MEMWB_WriteReg(MEMWB_WriteReg), .MEMWB_RegWrite(MEMWB_RegWrite),
        .Mem_Ready(Mem_Ready),
        .Ctrl_FwdA(Ctrl_FwdA), .Ctrl_FwdB(Ctrl_FwdB),
        .Ctrl_Mux_Select_Stall(Ctrl_Mux_Select_Stall), .PCWrite(PCWrite),
        .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .Pipe_Freeze(Pipe_Freeze),
        .Mem_Timeout_Err(Mem_Timeout_Err), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        IFID_Rs = 0; IFID_Rt = 0; ID_UsesRt = 0; ID_Branch = 0; ID_JR = 0; ID_Redirect = 0;
        IDEX_Rs = 0; IDEX_Rt = 0; IDEX_WriteReg = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
        EXMEM_WriteReg = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_MemWrite = 0;
        MEMWB_WriteReg = 0; MEMWB_RegWrite = 0; Mem_Ready = 1;
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // {Select_Stall, PCWrite, IFID_Write, IFID_Flush, Pipe_Freeze}
    function automatic logic [4:0] ctl();
        return {Ctrl_Mux_Select_Stall, PCWrite, IFID_Write, IFID_Flush, Pipe_Freeze};
    endfunction

    initial begin
        idle();
        #1;
        chk("reset_ctl", ctl(), 5'b11100);
        chk("reset_fwd", {Ctrl_FwdA, Ctrl_FwdB}, 4'd0);
        chk("reset_cnt", {Stall_Count, Flush_Count}, 0);
        chk("reset_err", Mem_Timeout_Err, 0);
        tick(); tick();
        reset = 1'b0;

        // Forwarding priority and $0 exclusion
        EXMEM_RegWrite = 1; EXMEM_WriteReg = 8; MEMWB_RegWrite = 1; MEMWB_WriteReg = 8; IDEX_Rs = 8;
        #1 chk("fwdA_exmem_wins", Ctrl_FwdA, 1);
        chk("fwdB_none", Ctrl_FwdB, 0);
        EXMEM_RegWrite = 0; IDEX_Rt = 8;
        #1 chk("fwdA_memwb", Ctrl_FwdA, 2);
        chk("fwdB_memwb", Ctrl_FwdB, 2);
        EXMEM_RegWrite = 1; EXMEM_WriteReg = 0; MEMWB_WriteReg = 0; IDEX_Rs = 0; IDEX_Rt = 0;
        #1 chk("fwd_r0", {Ctrl_FwdA, Ctrl_FwdB}, 0);
        chk("fwd_ctl_pass", ctl(), 5'b11100);

        // Load-use: one stall cycle
        idle(); IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 9; IFID_Rs = 9;
        #1 chk("lu_ctl", ctl(), 5'b00000);
        tick(); idle();
        #1 chk("lu_after_ctl", ctl(), 5'b11100);
        chk("lu_stall_cnt", Stall_Count, 1);
        IDEX_MemRead = 1; IDEX_WriteReg = 9; IFID_Rs = 3; IFID_Rt = 9; ID_UsesRt = 0;
        #1 chk("lu_rt_unused", ctl(), 5'b11100);

        // Load then beq: two stalls, redirect ignored while stalled, then flush
        tick(); idle(); IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 9;
        IFID_Rs = 9; IFID_Rt = 4; ID_UsesRt = 1; ID_Branch = 1; ID_Redirect = 1;
        #1 chk("br_stall1", ctl(), 5'b00000);
        tick(); IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
        EXMEM_MemRead = 1; EXMEM_RegWrite = 1; EXMEM_WriteReg = 9;
        #1 chk("br_stall2", ctl(), 5'b00000);
        tick(); EXMEM_MemRead = 0; EXMEM_RegWrite = 0; EXMEM_WriteReg = 0;
        MEMWB_RegWrite = 1; MEMWB_WriteReg = 9;
        #1 chk("br_stall_cnt", Stall_Count, 3);
        chk("br_flush_ctl", ctl(), 5'b11110);
        tick(); idle();
        #1 chk("br_flush_cnt", Flush_Count, 1);

        // Freeze 3 cycles over a pending load-use; stall resumes after Mem_Ready
        EXMEM_MemWrite = 1; Mem_Ready = 0;
        IDEX_MemRead = 1; IDEX_WriteReg = 5; IFID_Rs = 5; ID_Redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("frz_ctl%0d", i), ctl(), 5'b10001);
            tick();
        end
        Mem_Ready = 1;
        #1 chk("frz_cnt", {Stall_Count, Flush_Count}, {4'd3, 4'd1});
        chk("frz_resume_ctl", ctl(), 5'b00000);
        tick(); idle();
        #1 chk("frz_resume_cnt", Stall_Count, 4);

        // Timeout boundary, sticky flag, async reset mid-wait
        EXMEM_MemRead = 1; Mem_Ready = 0;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
        #1 chk("to_before", Mem_Timeout_Err, 0);
        tick();
        #1 chk("to_set", Mem_Timeout_Err, 1);
        Mem_Ready = 1;
        tick();
        #1 chk("to_sticky", Mem_Timeout_Err, 1);
        Mem_Ready = 0;
        tick(); tick();
        #1 reset = 1'b1;
        #1 chk("rst_mid_err", Mem_Timeout_Err, 0);
        chk("rst_mid_cnt", {Stall_Count, Flush_Count}, 0);
        idle();
        tick();
        reset = 1'b0;
        #1 chk("rst_mid_ctl", ctl(), 5'b11100);
        EXMEM_MemRead = 1; Mem_Ready = 0;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
        #1 chk("rst_wait_cleared", Mem_Timeout_Err, 0);
        tick(); idle(); reset = 1'b1;
        tick(); reset = 1'b0;

        // Stall counter saturation
        IDEX_MemRead = 1; IDEX_WriteReg = 7; IFID_Rs = 7;
        for (int i = 0; i < 15; i++) tick();
        #1 chk("sat_full", Stall_Count, 15);
        tick();
        #1 chk("sat_hold", Stall_Count, 15);
        chk("sat_flush", Flush_Count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
